// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: IFETCH_PERF_CNT_EN (adds fetch/discard counters).
package ifetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 12;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 12'h000;

  // Fetch sequencer states; encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  // One prefetch buffer entry: the word and the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // 16-bit add that sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries.
// flush wins over push/pop in the same cycle; push is accepted when full
// only if a pop frees a slot in the same cycle; pop on empty is ignored.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches from program ROM over
// req/ack, buffers words in a prefetch FIFO and hands them to the core.
// Optional feature macro: IFETCH_PERF_CNT_EN adds fetch_cnt/discard_cnt.
//
// Handshakes: rom_req/rom_addr are held until a cycle with rom_ack, and the
// word arrives in that same cycle. An instruction transfers on any cycle
// with instr_valid && instr_ready, unless jmp_en is high in that cycle
// (the redirect flushes the buffer and the transfer is cancelled).
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               rom_req,
  output logic [PC_W-1:0]    rom_addr,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_bus,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_addr,
`ifdef IFETCH_PERF_CNT_EN
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        discard_cnt,
`endif
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] hold_addr_q;
  logic          discard_q;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  // An ack only counts while we are actually requesting.
  assign accept    = (state_q == FETCH) && rom_ack;
  // Acked words are dropped when stale (discard) or overtaken by a redirect.
  assign push      = accept && !discard_q && !jmp_en;
  assign pop       = instr_valid && instr_ready && !jmp_en;
  assign push_data = '{pc: pc_q, instr: rom_data};

  // While a stale request is outstanding the address must not move.
  assign rom_addr    = discard_q ? hold_addr_q : pc_q;
  assign instr_valid = !empty;
  assign instr_bus   = empty ? NOP_INSTR : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;
  assign state_dbg   = state_q;

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jmp_en),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // Occupancy after this cycle's push/pop/flush, used to decide on the next request.
  always_comb begin
    count_next = count;
    if (jmp_en)             count_next = '0;
    else if (push && !pop)  count_next = count + CW'(1);
    else if (pop && !push)  count_next = count - CW'(1);
  end

  // Next-state and request generation; a request exists only in FETCH.
  always_comb begin
    state_d = state_q;
    rom_req = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        rom_req = 1'b1;
        if (accept && (count_next >= CW'(FIFO_DEPTH))) state_d = FULL;
      end
      FULL: begin
        if (count_next < CW'(FIFO_DEPTH)) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // PC, redirect and stale-request tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= '0;
      hold_addr_q <= '0;
      discard_q   <= 1'b0;
    end else begin
      if (jmp_en)    pc_q <= jmp_addr;
      else if (push) pc_q <= pc_q + PC_W'(1);
      if (accept) begin
        discard_q <= 1'b0;
      end else if (jmp_en && (state_q == FETCH)) begin
        discard_q <= 1'b1;
        if (!discard_q) hold_addr_q <= pc_q;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic        drop_word;
  logic [15:0] discard_inc;

  assign drop_word = accept && (discard_q || jmp_en);

  // Words lost this cycle: a dropped ack plus everything flushed.
  always_comb begin
    discard_inc = {15'd0, drop_word};
    if (jmp_en) discard_inc = discard_inc + 16'(count);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      fetch_cnt   <= sat_add16(fetch_cnt, {15'd0, pop});
      discard_cnt <= sat_add16(discard_cnt, discard_inc);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM model, directed redirect/reset
// scenarios, and a scoreboard monitor on the instruction bus.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic        rom_ack;
  logic [11:0] rom_data;
  logic        instr_valid;
  logic [11:0] instr_bus;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic [1:0]  state_dbg;
`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] discard_cnt;
`endif

  logic        ack_allow;
  int          checks;
  int          errors;
  logic [19:0] exp_q[$];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_bus   (instr_bus),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .discard_cnt (discard_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // ROM contents: every address holds a distinct word.
  function automatic logic [11:0] rom_word(input logic [7:0] a);
    return {a[3:0] ^ 4'hA, a};
  endfunction

  assign rom_ack  = rom_req && ack_allow;
  assign rom_data = rom_word(rom_addr);

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic expect_pc(input logic [7:0] pc);
    exp_q.push_back({pc, rom_word(pc)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold ready until the scoreboard is empty; bounded by a cycle budget.
  task automatic drain(input int budget, input bit keep_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    if (!keep_ready) instr_ready = 1'b0;
  endtask

  // Scoreboard monitor: compare every accepted instruction with the queue head.
  task automatic monitor();
    logic [19:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready && !jmp_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_instr: got pc %0h bus %0h expected none", instr_pc, instr_bus);
        end else begin
          exp = exp_q.pop_front();
          if ({instr_pc, instr_bus} !== exp) begin
            errors++;
            $display("FAIL instr_delivery: got pc %0h bus %0h expected pc %0h bus %0h",
                     instr_pc, instr_bus, exp[19:12], exp[11:0]);
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    jmp_en      = 1'b0;
    jmp_addr    = 8'h00;
    ack_allow   = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) tick();
    at_neg();
    check("rst_rom_req", 32'(rom_req), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_bus", 32'(instr_bus), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // First fetch latency with the core stalled, then buffering limit
    tick();
    rst_n = 1'b1;
    n = 0;
    at_neg();
    while (!(rom_req && rom_ack) && n < 10) begin
      at_neg();
      n++;
    end
    check("first_ack_seen", 32'(rom_req && rom_ack), 32'd1);
    check("first_addr", 32'(rom_addr), 32'd0);
    check("valid_before_push", 32'(instr_valid), 32'd0);
    at_neg();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_pc", 32'(instr_pc), 32'd0);
    check("first_bus", 32'(instr_bus), 32'(rom_word(8'h00)));
    repeat (10) tick();
    at_neg();
    check("stall_req_drop", 32'(rom_req), 32'd0);
    check("stall_state_full", 32'(state_dbg), 32'd2);
    check("stall_head_pc", 32'(instr_pc), 32'd0);

    // Release the core: in-order delivery, fetch resumes at 0x02
    tick();
    for (int i = 0; i < 10; i++) expect_pc(8'(i));
    instr_ready = 1'b1;
    at_neg();
    check("full_pop_no_req", 32'(rom_req), 32'd0);
    at_neg();
    check("resume_req", 32'(rom_req), 32'd1);
    check("resume_addr", 32'(rom_addr), 32'h02);
    drain(60, 1'b0);
    repeat (4) tick();

    // Redirect during a delayed ack: held address, stale word dropped
    ack_allow = 1'b0;
    expect_pc(8'h0A);
    expect_pc(8'h0B);
    instr_ready = 1'b1;
    drain(20, 1'b0);
    jmp_en   = 1'b1;
    jmp_addr = 8'h40;
    at_neg();
    check("jmp_wait_addr", 32'(rom_addr), 32'h0C);
    tick();
    jmp_en = 1'b0;
    at_neg();
    check("discard_req_held", 32'(rom_req), 32'd1);
    check("discard_addr_held", 32'(rom_addr), 32'h0C);
    check("discard_valid", 32'(instr_valid), 32'd0);
    tick();
    at_neg();
    check("discard_addr_held2", 32'(rom_addr), 32'h0C);
    tick();
    ack_allow = 1'b1;
    at_neg();
    check("stale_ack_addr", 32'(rom_addr), 32'h0C);
    tick();
    at_neg();
    check("redirect_addr", 32'(rom_addr), 32'h40);
    check("stale_word_dropped", 32'(instr_valid), 32'd0);
    expect_pc(8'h40);
    expect_pc(8'h41);
    expect_pc(8'h42);
    tick();
    instr_ready = 1'b1;
    drain(40, 1'b0);
    repeat (4) tick();

    // Redirect coincident with a pop and an ack
    expect_pc(8'h43);
    expect_pc(8'h44);
    expect_pc(8'h45);
    instr_ready = 1'b1;
    drain(40, 1'b1);
    jmp_en   = 1'b1;
    jmp_addr = 8'h80;
    expect_pc(8'h80);
    expect_pc(8'h81);
    at_neg();
    check("coinc_valid", 32'(instr_valid), 32'd1);
    check("coinc_ack", 32'(rom_ack), 32'd1);
    tick();
    jmp_en = 1'b0;
    at_neg();
    check("coinc_flushed", 32'(instr_valid), 32'd0);
    check("coinc_addr", 32'(rom_addr), 32'h80);
    drain(40, 1'b0);
    repeat (4) tick();

    // PC wrap 0xFF -> 0x00
    jmp_en      = 1'b1;
    jmp_addr    = 8'hFE;
    instr_ready = 1'b1;
    expect_pc(8'hFE);
    expect_pc(8'hFF);
    expect_pc(8'h00);
    tick();
    jmp_en = 1'b0;
    at_neg();
    check("wrap_addr_fe", 32'(rom_addr), 32'hFE);
    tick();
    at_neg();
    check("wrap_addr_ff", 32'(rom_addr), 32'hFF);
    tick();
    at_neg();
    check("wrap_addr_00", 32'(rom_addr), 32'h00);
    drain(40, 1'b0);
    repeat (4) tick();

    // Reset while a request is outstanding
    ack_allow = 1'b0;
    expect_pc(8'h01);
    expect_pc(8'h02);
    instr_ready = 1'b1;
    drain(20, 1'b0);
    at_neg();
    check("midfetch_req", 32'(rom_req), 32'd1);
    check("midfetch_addr", 32'(rom_addr), 32'h03);
    tick();
    rst_n = 1'b0;
    tick();
    at_neg();
    check("midrst_req", 32'(rom_req), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_addr", 32'(rom_addr), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst_discard_cnt", 32'(discard_cnt), 32'd0);
`endif

    // Restart at 0x00, five pops, then flush two entries and one in-flight word
    ack_allow = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) expect_pc(8'(i));
    repeat (5) tick();
    at_neg();
    check("restart_full", 32'(state_dbg), 32'd2);
    check("restart_pc", 32'(instr_pc), 32'h00);
    tick();
    instr_ready = 1'b1;
    drain(40, 1'b0);
    repeat (4) tick();
    ack_allow = 1'b0;
    jmp_en    = 1'b1;
    jmp_addr  = 8'h20;
    tick();
    jmp_addr  = 8'h30;
    tick();
    jmp_en = 1'b0;
    at_neg();
    check("second_jmp_addr_held", 32'(rom_addr), 32'h20);
    tick();
    ack_allow = 1'b1;
    at_neg();
    check("second_jmp_stale_ack", 32'(rom_ack), 32'd1);
    tick();
    at_neg();
    check("second_jmp_target", 32'(rom_addr), 32'h30);
    check("second_jmp_valid", 32'(instr_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetch_cnt", 32'(fetch_cnt), 32'd5);
    check("perf_discard_cnt", 32'(discard_cnt), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
